// File: rtl/alu_arbiter.sv
// Round-robin arbiter: two requesters share one combinational ALU, one operation in flight at a time.
// Build option: define ALU_ARBITER_STATS_EN to add saturating per-requester grant counters.
//
//   state | meaning
//   IDLE  | waiting for a request; grants one and drives its operands to the ALU
//   EXEC  | ALU inputs are stable; capture result and zero flag
//   RESP  | response held on o_rsp_* until the consumer accepts it
module alu_arbiter #(
  parameter int NBITS  = 32,
  parameter int RNBITS = 5,
  parameter int NB_OP  = 4
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_req0_valid,
  output logic              o_req0_ready,
  input  logic [NBITS-1:0]  i_req0_data_1,
  input  logic [NBITS-1:0]  i_req0_data_2,
  input  logic [RNBITS-1:0] i_req0_shamt,
  input  logic              i_req0_ushamt,
  input  logic [NB_OP-1:0]  i_req0_operation,
  input  logic              i_req1_valid,
  output logic              o_req1_ready,
  input  logic [NBITS-1:0]  i_req1_data_1,
  input  logic [NBITS-1:0]  i_req1_data_2,
  input  logic [RNBITS-1:0] i_req1_shamt,
  input  logic              i_req1_ushamt,
  input  logic [NB_OP-1:0]  i_req1_operation,
  output logic [NBITS-1:0]  o_alu_data_1,
  output logic [NBITS-1:0]  o_alu_data_2,
  output logic [RNBITS-1:0] o_alu_shamt,
  output logic              o_alu_ushamt,
  output logic [NB_OP-1:0]  o_alu_operation,
  input  logic [NBITS-1:0]  i_alu_result,
  input  logic              i_alu_cero,
  output logic              o_rsp_valid,
  output logic              o_rsp_id,
  output logic [NBITS-1:0]  o_rsp_result,
  output logic              o_rsp_cero,
  input  logic              i_rsp_ready,
  output logic [15:0]       o_grant_cnt0,
  output logic [15:0]       o_grant_cnt1
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t state, state_nxt;
  logic   ptr;
  logic   grant;
  logic   grant_id;

  always_comb begin
    state_nxt    = state;
    grant        = 1'b0;
    grant_id     = 1'b0;
    o_req0_ready = 1'b0;
    o_req1_ready = 1'b0;
    case (state)
      IDLE: begin
        if (i_req0_valid || i_req1_valid) begin
          grant = 1'b1;
          // pointer only matters when both compete; a lone requester always wins
          grant_id     = (i_req0_valid && i_req1_valid) ? ptr : i_req1_valid;
          o_req0_ready = !grant_id;
          o_req1_ready = grant_id;
          state_nxt    = EXEC;
        end
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (i_rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state           <= IDLE;
      ptr             <= 1'b0;
      o_alu_data_1    <= '0;
      o_alu_data_2    <= '0;
      o_alu_shamt     <= '0;
      o_alu_ushamt    <= 1'b0;
      o_alu_operation <= '0;
      o_rsp_valid     <= 1'b0;
      o_rsp_id        <= 1'b0;
      o_rsp_result    <= '0;
      o_rsp_cero      <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        ptr             <= !grant_id;
        o_rsp_id        <= grant_id;
        o_alu_data_1    <= grant_id ? i_req1_data_1    : i_req0_data_1;
        o_alu_data_2    <= grant_id ? i_req1_data_2    : i_req0_data_2;
        o_alu_shamt     <= grant_id ? i_req1_shamt     : i_req0_shamt;
        o_alu_ushamt    <= grant_id ? i_req1_ushamt    : i_req0_ushamt;
        o_alu_operation <= grant_id ? i_req1_operation : i_req0_operation;
      end
      if (state == EXEC) begin
        o_rsp_result <= i_alu_result;
        o_rsp_cero   <= i_alu_cero;
        o_rsp_valid  <= 1'b1;
      end else if (state == RESP && i_rsp_ready) begin
        o_rsp_valid <= 1'b0;
      end
    end
  end

`ifdef ALU_ARBITER_STATS_EN
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_grant_cnt0 <= '0;
      o_grant_cnt1 <= '0;
    end else if (grant) begin
      if (!grant_id && o_grant_cnt0 != 16'hFFFF) o_grant_cnt0 <= o_grant_cnt0 + 16'd1;
      if (grant_id && o_grant_cnt1 != 16'hFFFF)  o_grant_cnt1 <= o_grant_cnt1 + 16'd1;
    end
  end
`else
  assign o_grant_cnt0 = 16'h0000;
  assign o_grant_cnt1 = 16'h0000;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: vector table, directed corner sequences and random traffic
// checked by a transaction-level monitor (one operation outstanding, alternating priority).
module tb_alu_arbiter;
  localparam int NBITS = 32, RNBITS = 5, NB_OP = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic v0, v1, r0, r1;
  logic [NBITS-1:0] a0, b0, a1, b1;
  logic [RNBITS-1:0] s0, s1;
  logic u0, u1;
  logic [NB_OP-1:0] op0, op1;
  logic [NBITS-1:0] alu_d1, alu_d2, alu_res;
  logic [RNBITS-1:0] alu_sh;
  logic alu_ush, alu_cero;
  logic [NB_OP-1:0] alu_op;
  logic rsp_valid, rsp_id, rsp_cero, rsp_ready;
  logic [NBITS-1:0] rsp_result;
  logic [15:0] cnt0, cnt1;

  int tests = 0, fails = 0;

  alu_arbiter #(.NBITS(NBITS), .RNBITS(RNBITS), .NB_OP(NB_OP)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_req0_valid(v0), .o_req0_ready(r0), .i_req0_data_1(a0), .i_req0_data_2(b0),
    .i_req0_shamt(s0), .i_req0_ushamt(u0), .i_req0_operation(op0),
    .i_req1_valid(v1), .o_req1_ready(r1), .i_req1_data_1(a1), .i_req1_data_2(b1),
    .i_req1_shamt(s1), .i_req1_ushamt(u1), .i_req1_operation(op1),
    .o_alu_data_1(alu_d1), .o_alu_data_2(alu_d2), .o_alu_shamt(alu_sh),
    .o_alu_ushamt(alu_ush), .o_alu_operation(alu_op),
    .i_alu_result(alu_res), .i_alu_cero(alu_cero),
    .o_rsp_valid(rsp_valid), .o_rsp_id(rsp_id), .o_rsp_result(rsp_result),
    .o_rsp_cero(rsp_cero), .i_rsp_ready(rsp_ready),
    .o_grant_cnt0(cnt0), .o_grant_cnt1(cnt1)
  );

  // the shared ALU living outside the arbiter
  function automatic logic [NBITS-1:0] alu_f(input logic [NB_OP-1:0] op,
                                             input logic [NBITS-1:0] a, input logic [NBITS-1:0] b,
                                             input logic [RNBITS-1:0] sh);
    case (op)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0011: return a ^ b;
      4'b0100: return b << sh;
      4'b0110: return a - b;
      default: return '0;
    endcase
  endfunction

  assign alu_res  = alu_f(alu_op, alu_d1, alu_d2, alu_sh);
  assign alu_cero = (alu_res == '0);

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level monitor ----------------
  typedef struct {
    logic id;
    logic [NBITS-1:0] d1, d2;
    logic [RNBITS-1:0] sh;
    logic ush;
    logic [NB_OP-1:0] op;
  } txn_t;

  txn_t q[$];
  bit busy = 0, ptr_m = 0;
  int cyc = 0, gcyc = 0, nrsp = 0;
  int gcnt[2] = '{0, 0};
  logic exp_id;
  txn_t t;
  logic [NBITS-1:0] exp_res;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      busy = 0; ptr_m = 0; q.delete(); gcnt = '{0, 0};
    end else begin
      chk("one_ready", {63'd0, r0 & r1}, 64'd0);
      if (!busy) begin
        chk("idle_no_rsp", {63'd0, rsp_valid}, 64'd0);
        if (v0 || v1) begin
          exp_id = (v0 && v1) ? ptr_m : (v0 ? 1'b0 : 1'b1);
          chk("grant_r0", {63'd0, r0}, {63'd0, !exp_id});
          chk("grant_r1", {63'd0, r1}, {63'd0, exp_id});
          t.id = exp_id;
          t.d1 = exp_id ? a1 : a0;  t.d2 = exp_id ? b1 : b0;
          t.sh = exp_id ? s1 : s0;  t.ush = exp_id ? u1 : u0;
          t.op = exp_id ? op1 : op0;
          q.push_back(t);
          busy = 1; gcyc = cyc; ptr_m = !exp_id; gcnt[exp_id]++;
        end else begin
          chk("idle_ready_low", {62'd0, r0, r1}, 64'd0);
        end
      end else begin
        chk("busy_ready_low", {62'd0, r0, r1}, 64'd0);
        t = q[0];
        chk("alu_regs", {alu_ush, alu_op, alu_sh, alu_d1, 22'd0},
            {t.ush, t.op, t.sh, t.d1, 22'd0});
        chk("alu_d2", {32'd0, alu_d2}, {32'd0, t.d2});
        if (cyc == gcyc + 1) begin
          chk("exec_no_rsp", {63'd0, rsp_valid}, 64'd0);
        end else begin
          exp_res = alu_f(t.op, t.d1, t.d2, t.sh);
          chk("rsp_valid", {63'd0, rsp_valid}, 64'd1);
          chk("rsp_id", {63'd0, rsp_id}, {63'd0, t.id});
          chk("rsp_result", {32'd0, rsp_result}, {32'd0, exp_res});
          chk("rsp_cero", {63'd0, rsp_cero}, {63'd0, exp_res == '0});
          if (rsp_ready) begin
            void'(q.pop_front());
            busy = 0; nrsp++;
          end
        end
      end
    end
  end

  // ---------------- driver helpers ----------------
  task automatic drive(input bit id, input bit v, input logic [NBITS-1:0] d1,
                       input logic [NBITS-1:0] d2, input logic [NB_OP-1:0] op);
    if (id) begin v1 = v; a1 = d1; b1 = d2; op1 = op; s1 = d1[4:0]; u1 = d2[0]; end
    else    begin v0 = v; a0 = d1; b0 = d2; op0 = op; s0 = d1[4:0]; u0 = d2[0]; end
  endtask

  task automatic wait_grant(input string name, output logic gid);
    gid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (r0 || r1) begin gid = r1; return; end
    end
    chk({name, "_grant_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic wait_rsp(input string name);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (rsp_valid && rsp_ready) return;
    end
    chk({name, "_rsp_timeout"}, 64'd1, 64'd0);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1; v0 = 0; v1 = 0;
    repeat (2) @(posedge clk);
    #1 rst = 0;
  endtask

  task automatic single(input bit id, input logic [NBITS-1:0] d1, input logic [NBITS-1:0] d2,
                        input logic [NB_OP-1:0] op);
    logic g;
    @(posedge clk); #1 drive(id, 1, d1, d2, op);
    wait_grant("single", g);
    chk("single_gid", {63'd0, g}, {63'd0, id});
    @(posedge clk); #1 drive(id, 0, '0, '0, '0);
    wait_rsp("single");
  endtask

  typedef struct {
    bit id;
    logic [NBITS-1:0] d1, d2;
    logic [NB_OP-1:0] op;
    logic [NBITS-1:0] exp_res;
    bit exp_cero;
  } vec_t;

  vec_t vt[6];
  logic g;
  logic [NBITS-1:0] held_res;
  logic held_id, held_cero;
  int grants[$];
  int seen_rsp;

  initial begin
    vt[0] = '{0, 32'd2, 32'd1, 4'b0010, 32'd3, 0};
    vt[1] = '{1, 32'd5, 32'd5, 4'b0110, 32'd0, 1};
    vt[2] = '{0, 32'hF0, 32'h0F, 4'b0001, 32'hFF, 0};
    vt[3] = '{1, 32'hFFFFFFFF, 32'd1, 4'b0010, 32'd0, 1};
    vt[4] = '{0, 32'hAA, 32'h55, 4'b0000, 32'd0, 1};
    vt[5] = '{1, 32'd4, 32'h3, 4'b0100, 32'h30, 0};

    rst = 1; v0 = 0; v1 = 0; rsp_ready = 1;
    drive(0, 0, '0, '0, '0); drive(1, 0, '0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {r0, r1, rsp_valid, rsp_id, rsp_cero, alu_ush, alu_op, alu_sh},  64'd0);
    chk("reset_data", {rsp_result, alu_d1}, 64'd0);
    chk("reset_d2", {32'd0, alu_d2}, 64'd0);
    chk("reset_cnt", {32'd0, cnt0, cnt1}, 64'd0);
    @(posedge clk); #1 rst = 0;

    // vector table: one transaction per row
    for (int i = 0; i < 6; i++) begin
      single(vt[i].id, vt[i].d1, vt[i].d2, vt[i].op);
      chk("vec_result", {32'd0, rsp_result}, {32'd0, vt[i].exp_res});
      chk("vec_cero", {63'd0, rsp_cero}, {63'd0, vt[i].exp_cero});
      chk("vec_id", {63'd0, rsp_id}, {63'd0, vt[i].id});
    end

    // both valid right after reset: requester 0 first
    do_reset();
    @(posedge clk); #1;
    drive(0, 1, 32'd5, 32'd5, 4'b0110);
    drive(1, 1, 32'd2, 32'd1, 4'b0001);
    wait_grant("both", g);
    chk("both_first", {63'd0, g}, 64'd0);
    @(posedge clk); #1 drive(0, 0, '0, '0, '0);
    wait_rsp("both0");
    chk("both0_res", {32'd0, rsp_result}, 64'd0);
    chk("both0_cero", {63'd0, rsp_cero}, 64'd1);
    wait_grant("both1", g);
    chk("both_second", {63'd0, g}, 64'd1);
    @(posedge clk); #1 drive(1, 0, '0, '0, '0);
    wait_rsp("both1");
    chk("both1_res", {32'd0, rsp_result}, 64'd3);
    chk("both1_id", {63'd0, rsp_id}, 64'd1);

    // continuous contention: strict alternation
    do_reset();
    @(posedge clk); #1;
    drive(0, 1, 32'd7, 32'd1, 4'b0010);
    drive(1, 1, 32'd9, 32'd2, 4'b0110);
    grants.delete();
    for (int i = 0; i < 40 && grants.size() < 6; i++) begin
      @(negedge clk);
      if (r0 || r1) grants.push_back(int'(r1));
    end
    @(posedge clk); #1 begin v0 = 0; v1 = 0; end
    chk("rr_count", 64'(grants.size()), 64'd6);
    for (int i = 0; i < grants.size(); i++) chk("rr_order", 64'(grants[i]), 64'(i % 2));
    wait_rsp("rr_drain");

    // consumer stalls in RESP for 5 cycles while the other requester waits
    @(posedge clk); #1 rsp_ready = 0; drive(0, 1, 32'h11, 32'h22, 4'b0011);
    wait_grant("stall", g);
    @(posedge clk); #1 begin drive(0, 0, '0, '0, '0); drive(1, 1, 32'd1, 32'd1, 4'b0010); end
    for (int i = 0; i < 10 && !rsp_valid; i++) @(negedge clk);
    held_res = rsp_result; held_id = rsp_id; held_cero = rsp_cero;
    chk("stall_val", {32'd0, held_res}, 64'h33);
    seen_rsp = nrsp;
    repeat (5) begin
      @(negedge clk);
      chk("stall_hold", {rsp_valid, rsp_id, rsp_cero, 29'd0, rsp_result},
          {1'b1, held_id, held_cero, 29'd0, held_res});
      chk("stall_no_ready", {62'd0, r0, r1}, 64'd0);
    end
    chk("stall_no_rsp", 64'(nrsp - seen_rsp), 64'd0);
    @(posedge clk); #1 rsp_ready = 1;
    wait_grant("stall_next", g);
    chk("stall_next_id", {63'd0, g}, 64'd1);
    chk("stall_one_rsp", 64'(nrsp - seen_rsp), 64'd1);
    @(posedge clk); #1 drive(1, 0, '0, '0, '0);
    wait_rsp("stall_drain");

    // reset while the operation is executing
    @(posedge clk); #1 drive(1, 1, 32'd3, 32'd4, 4'b0010);
    wait_grant("rst_exec", g);
    @(posedge clk); #1 begin rst = 1; drive(1, 0, '0, '0, '0); end
    @(negedge clk);
    chk("rst_mid_outs", {r0, r1, rsp_valid, rsp_id, rsp_cero, alu_ush, alu_op, alu_sh}, 64'd0);
    chk("rst_mid_data", {rsp_result, alu_d1}, 64'd0);
    @(posedge clk); #1 rst = 0;
    seen_rsp = 0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) seen_rsp++;
    end
    chk("rst_no_rsp", 64'(seen_rsp), 64'd0);

    // grant statistics
    do_reset();
    single(0, 1, 1, 4'b0010); single(0, 2, 2, 4'b0010); single(0, 3, 3, 4'b0010);
    single(1, 4, 4, 4'b0010); single(1, 5, 5, 4'b0010);
`ifdef ALU_ARBITER_STATS_EN
    chk("cnt0", {48'd0, cnt0}, 64'd3);
    chk("cnt1", {48'd0, cnt1}, 64'd2);
`else
    chk("cnt0_off", {48'd0, cnt0}, 64'd0);
    chk("cnt1_off", {48'd0, cnt1}, 64'd0);
`endif

    // random traffic against the monitor model
    for (int i = 0; i < 400; i++) begin
      @(posedge clk); #1;
      v0 = ($urandom_range(0, 2) != 0);
      v1 = ($urandom_range(0, 2) != 0);
      a0 = $urandom; b0 = $urandom; a1 = $urandom; b1 = $urandom;
      s0 = RNBITS'($urandom); s1 = RNBITS'($urandom);
      u0 = 1'($urandom); u1 = 1'($urandom);
      op0 = NB_OP'($urandom_range(0, 7)); op1 = NB_OP'($urandom_range(0, 7));
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1 begin v0 = 0; v1 = 0; rsp_ready = 1; end
    repeat (6) @(negedge clk);
    chk("random_drained", 64'(q.size()), 64'd0);
`ifdef ALU_ARBITER_STATS_EN
    chk("rand_cnt0", {48'd0, cnt0}, 64'(gcnt[0] > 65535 ? 65535 : gcnt[0]));
    chk("rand_cnt1", {48'd0, cnt1}, 64'(gcnt[1] > 65535 ? 65535 : gcnt[1]));
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter NBITS, default 32, operand/result width SHALL be NBITS.
REQ-002 Parameter RNBITS, default 5, shamt width SHALL be RNBITS.
REQ-003 Parameter NB_OP, default 4, operation code width SHALL be NB_OP.
REQ-004 i_clk  in  1  single clock; all state SHALL update on its rising edge.
REQ-005 i_reset  in  1  asynchronous, active-high reset.
REQ-006 i_req0_valid / i_req1_valid  in  1  requester n presents an operation.
REQ-007 o_req0_ready / o_req1_ready  out  1  one-cycle grant pulse; operands accepted when valid&ready.
REQ-008 i_reqN_data_1, i_reqN_data_2  in  NBITS  operands of requester N.
REQ-009 i_reqN_shamt  in  RNBITS; i_reqN_ushamt  in  1; i_reqN_operation  in  NB_OP: shift amount, shamt-select, ALU op code.
REQ-010 o_alu_data_1, o_alu_data_2  out  NBITS; o_alu_shamt  out  RNBITS; o_alu_ushamt  out  1; o_alu_operation  out  NB_OP: registered drive to shared ALU.
REQ-011 i_alu_result  in  NBITS; i_alu_cero  in  1: combinational ALU return.
REQ-012 o_rsp_valid  out  1; o_rsp_id  out  1 (granted requester); o_rsp_result  out  NBITS; o_rsp_cero  out  1.
REQ-013 i_rsp_ready  in  1  response consumer accepts when o_rsp_valid&i_rsp_ready.

Function
REQ-014 FSM states SHALL be IDLE, EXEC, RESP.
REQ-015 IDLE: if either valid, SHALL grant one requester, assert its ready for that cycle only, latch its operands into o_alu_* registers, record id, go EXEC; else stay IDLE.
REQ-016 Only one ready SHALL be high in any cycle; ready SHALL be low outside IDLE.
REQ-017 Arbitration SHALL be round-robin: priority pointer favours requester 0 after reset; after each grant pointer SHALL point to the non-granted requester.
REQ-018 Single valid SHALL be granted regardless of pointer.
REQ-019 EXEC: SHALL capture i_alu_result, i_alu_cero into response registers, set o_rsp_valid, go RESP.
REQ-020 RESP: o_rsp_valid, o_rsp_id, o_rsp_result, o_rsp_cero SHALL hold stable until handshake; on handshake SHALL clear o_rsp_valid and go IDLE.
REQ-021 Latency: grant at cycle N SHALL yield o_rsp_valid at N+2; min issue interval SHALL be 3 cycles with i_rsp_ready held high.
REQ-022 Valid deasserted by a requester while not granted SHALL drop its request without side effects.
REQ-023 o_alu_* SHALL hold last granted operands while IDLE/RESP (no toggling on idle).

Reset
REQ-024 Reset SHALL force: state IDLE, pointer to requester 0, o_req*_ready 0, o_rsp_valid 0, o_rsp_id 0, o_rsp_result 0, o_rsp_cero 0, all o_alu_* 0.
REQ-025 Reset asserted mid-EXEC or mid-RESP SHALL discard the in-flight operation; no response emitted after release.

Configuration
REQ-026 Macro ALU_ARBITER_STATS_EN defined: outputs o_grant_cnt0, o_grant_cnt1 (16 bits each) SHALL count grants per requester, saturate at 16'hFFFF, reset to 0.
REQ-027 Macro undefined: o_grant_cnt0/1 SHALL exist and be tied to 0; no counter logic.

Verification
REQ-028 Req0 only: data_1=2, data_2=1, op=4'b0010 -> o_rsp_valid at N+2, result 3, id 0, cero 0.
REQ-029 Both valid after reset, req0 SUB(5,5) op=4'b0110, req1 OR(2,1) op=4'b0001 -> req0 first: result 0, cero 1; then req1: result 3, id 1.
REQ-030 Both held valid continuously for 6 grants -> grant order 0,1,0,1,0,1; never two readies in one cycle.
REQ-031 i_rsp_ready low 5 cycles during RESP -> response fields stable, no new ready, one response per grant.
REQ-032 i_reset asserted in EXEC -> next cycle all outputs at reset values; no o_rsp_valid after release without new request.
REQ-033 With ALU_ARBITER_STATS_EN: 3 grants req0, 2 grants req1 -> o_grant_cnt0=3, o_grant_cnt1=2; without macro both read 0.
